// File: rtl/if_fetch_pc.sv
// Fetch PC stage: next-PC select, stall hold, 1-cycle imem realignment; optional flush via IF_REDIRECT_FLUSH_EN.
// Latency: pc in cycle N -> instr/instr_pc in cycle N+1.
// Backpressure: stall freezes pc and the instr/instr_pc/instr_valid triple; redirects during stall are queued.
module if_fetch_pc #(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        if_sel,
    input  logic [31:0] ic_dout,
    input  logic [31:0] bios_dout,
    output logic [31:0] pc,
    output logic        stall_reg,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid
);

    logic [31:0] pc_nxt;
    logic [31:0] tgt_aligned;
    logic [31:0] pend_tgt;
    logic        pend_vld;
    logic [31:0] pc_q;
    logic        sel_q;
    logic        fetched_q;
    logic        kill_q;
    logic [31:0] hold;
    logic [31:0] raw;

    assign tgt_aligned = redirect_target & 32'hFFFF_FFFC;

    always_comb begin
        pc_nxt = pc + 32'd4;
        if (stall) begin
            pc_nxt = pc;
        end else if (redirect_valid) begin
            pc_nxt = tgt_aligned;
        end else if (pend_vld) begin
            pc_nxt = pend_tgt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_PC;
            stall_reg <= 1'b0;
            pend_vld  <= 1'b0;
            pend_tgt  <= 32'h0;
            pc_q      <= 32'h0;
            sel_q     <= 1'b0;
            fetched_q <= 1'b0;
            hold      <= NOP;
        end else begin
            pc        <= pc_nxt;
            stall_reg <= stall;
            // A redirect seen while stalled is remembered; the latest one wins.
            if (stall) begin
                if (redirect_valid) begin
                    pend_vld <= 1'b1;
                    pend_tgt <= tgt_aligned;
                end
            end else begin
                pend_vld  <= 1'b0;
                pc_q      <= pc;
                sel_q     <= if_sel;
                fetched_q <= 1'b1;
            end
            // Memory data moves on once the address is held, so capture it on stall entry.
            if (stall && !stall_reg) begin
                hold <= raw;
            end
        end
    end

`ifdef IF_REDIRECT_FLUSH_EN
    logic redirect_apply;
    assign redirect_apply = ~stall & (redirect_valid | pend_vld);

    always_ff @(posedge clk) begin
        if (reset) begin
            kill_q <= 1'b0;
        end else if (!stall) begin
            kill_q <= redirect_apply;
        end
    end
`else
    assign kill_q = 1'b0;
`endif

    assign raw         = sel_q ? bios_dout : ic_dout;
    assign instr_pc    = pc_q;
    assign instr_valid = fetched_q & ~kill_q;

    always_comb begin
        instr = NOP;
        if (instr_valid) begin
            instr = stall_reg ? hold : raw;
        end
    end

endmodule

// File: tb/tb_if_fetch_pc.sv
// Bench for if_fetch_pc: directed scenarios plus random traffic against a fetch-record model.
module tb_if_fetch_pc;

    localparam logic [31:0] RESET_PC = 32'h4000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;
`ifdef IF_REDIRECT_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_sel;
    logic [31:0] ic_dout;
    logic [31:0] bios_dout;
    logic [31:0] pc;
    logic        stall_reg;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;

    always #5 clk = ~clk;

    if_fetch_pc #(.RESET_PC(RESET_PC), .NOP(NOP)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .if_sel(if_sel), .ic_dout(ic_dout), .bios_dout(bios_dout),
        .pc(pc), .stall_reg(stall_reg), .instr(instr),
        .instr_pc(instr_pc), .instr_valid(instr_valid)
    );

    // Model: current fetch address, pending redirect, and the record of the
    // most recently accepted fetch (what decode should be looking at).
    logic [31:0] m_pc = RESET_PC;
    logic        m_sr = 1'b0;
    logic        m_pend = 1'b0;
    logic [31:0] m_ptgt = 32'h0;
    logic        r_valid = 1'b0;
    logic        r_kill = 1'b0;
    logic        r_sel = 1'b0;
    logic        r_new = 1'b0;
    logic [31:0] r_pc = 32'h0;
    logic [31:0] r_data = NOP;

    int n_tests = 0;
    int n_fail  = 0;

    logic [97:0] got_vec;
    assign got_vec = {pc, stall_reg, instr, instr_pc, instr_valid};

    function automatic logic [97:0] exp_vec();
        logic v;
        v = r_valid && !r_kill;
        return {m_pc, m_sr, (v ? r_data : NOP), r_pc, v};
    endfunction

    // Drive one cycle of inputs; a freshly accepted fetch takes its data from
    // the memory output in the first cycle it is on display.
    task automatic apply(input logic rst, input logic st, input logic rv, input logic [31:0] tgt,
                         input logic sel, input logic [31:0] ic, input logic [31:0] bios);
        reset = rst; stall = st; redirect_valid = rv; redirect_target = tgt;
        if_sel = sel; ic_dout = ic; bios_dout = bios;
        #2;
        if (r_new) begin
            r_data = r_sel ? bios_dout : ic_dout;
            r_new  = 1'b0;
        end
    endtask

    task automatic clock();
        logic applied;
        if (reset) begin
            m_pc = RESET_PC; m_sr = 1'b0; m_pend = 1'b0;
            r_valid = 1'b0; r_kill = 1'b0; r_new = 1'b0; r_pc = 32'h0;
        end else begin
            m_sr = stall;
            if (!stall) begin
                applied = redirect_valid || m_pend;
                r_valid = 1'b1; r_pc = m_pc; r_sel = if_sel; r_new = 1'b1;
                r_kill  = FLUSH && applied;
                if (redirect_valid)   m_pc = {redirect_target[31:2], 2'b00};
                else if (m_pend)      m_pc = m_ptgt;
                else                  m_pc = m_pc + 32'd4;
                m_pend = 1'b0;
            end else if (redirect_valid) begin
                m_pend = 1'b1;
                m_ptgt = {redirect_target[31:2], 2'b00};
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, $urandom(), $urandom());
        clock();
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, $urandom(), $urandom());
        n_tests++;
        if (pc !== RESET_PC || stall_reg !== 1'b0 || instr !== NOP || instr_pc !== 32'h0 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: got pc=%h sr=%b instr=%h ipc=%h v=%b, want pc=%h sr=0 instr=%h ipc=0 v=0",
                     pc, stall_reg, instr, instr_pc, instr_valid, RESET_PC, NOP);
        end
        clock();
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, $urandom(), $urandom());
            n_tests++;
            if (got_vec !== exp_vec()) begin
                n_fail++; $display("FAIL reset_release_model k=%0d: got %h want %h", k, got_vec, exp_vec());
            end
            n_tests++;
            if (pc !== RESET_PC + 32'(4 * k)) begin
                n_fail++; $display("FAIL reset_release_pc k=%0d: got %h want %h", k, pc, RESET_PC + 32'(4 * k));
            end
            if (k == 0) begin
                n_tests++;
                if (instr_valid !== 1'b0) begin
                    n_fail++; $display("FAIL reset_release_early_valid: got %b want 0", instr_valid);
                end
            end
            if (k == 1) begin
                n_tests++;
                if (instr_valid !== 1'b1 || instr_pc !== RESET_PC || instr !== bios_dout) begin
                    n_fail++; $display("FAIL reset_first_instr: got v=%b ipc=%h instr=%h want v=1 ipc=%h instr=%h",
                                       instr_valid, instr_pc, instr, RESET_PC, bios_dout);
                end
            end
            clock();
        end
    endtask

    task automatic test_icache();
        apply(1'b0, 1'b0, 1'b1, 32'h1000_0012, 1'b1, $urandom(), $urandom());
        n_tests++;
        if (got_vec !== exp_vec()) begin
            n_fail++; $display("FAIL icache_model c0: got %h want %h", got_vec, exp_vec());
        end
        clock();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, $urandom(), $urandom());
        n_tests++;
        if (pc !== 32'h1000_0010) begin
            n_fail++; $display("FAIL icache_redirect_pc: got %h want 10000010", pc);
        end
        clock();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, $urandom(), $urandom());
        n_tests++;
        if (instr_pc !== 32'h1000_0010 || instr !== ic_dout || instr_valid !== 1'b1) begin
            n_fail++; $display("FAIL icache_instr: got ipc=%h instr=%h v=%b want ipc=10000010 instr=%h v=1",
                               instr_pc, instr, instr_valid, ic_dout);
        end
        n_tests++;
        if (got_vec !== exp_vec()) begin
            n_fail++; $display("FAIL icache_model c2: got %h want %h", got_vec, exp_vec());
        end
        clock();
    endtask

    task automatic test_stall();
        bit          st_tab[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] p0;
        logic [31:0] x1;
        logic [31:0] bv;
        for (int k = 0; k < 2; k++) begin
            apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, $urandom(), $urandom());
            clock();
        end
        p0 = m_pc;
        x1 = $urandom();
        for (int k = 0; k < 5; k++) begin
            bv = (k == 0) ? x1 : (k == 1) ? 32'hDEAD_BEEF : $urandom();
            apply(1'b0, st_tab[k], 1'b0, 32'h0, 1'b1, $urandom(), bv);
            n_tests++;
            if (got_vec !== exp_vec()) begin
                n_fail++; $display("FAIL stall_model k=%0d: got %h want %h", k, got_vec, exp_vec());
            end
            n_tests++;
            if (pc !== ((k < 4) ? p0 : p0 + 32'd4)) begin
                n_fail++; $display("FAIL stall_pc k=%0d: got %h want %h", k, pc, (k < 4) ? p0 : p0 + 32'd4);
            end
            n_tests++;
            if (stall_reg !== ((k == 0) ? 1'b0 : st_tab[k-1])) begin
                n_fail++; $display("FAIL stall_reg k=%0d: got %b want %b", k, stall_reg, (k == 0) ? 1'b0 : st_tab[k-1]);
            end
            n_tests++;
            if (k < 4 && (instr !== x1 || instr_pc !== p0 - 32'd4 || instr_valid !== 1'b1)) begin
                n_fail++; $display("FAIL stall_hold k=%0d: got instr=%h ipc=%h v=%b want instr=%h ipc=%h v=1",
                                   k, instr, instr_pc, instr_valid, x1, p0 - 32'd4);
            end else if (k == 4 && (instr !== bios_dout || instr_pc !== p0)) begin
                n_fail++; $display("FAIL stall_resume: got instr=%h ipc=%h want instr=%h ipc=%h",
                                   instr, instr_pc, bios_dout, p0);
            end
            clock();
        end
    endtask

    task automatic test_pending();
        bit          st_a[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        bit          rv_a[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] tg_a[5]  = '{32'h4000_0100, 32'h4000_0200, 32'h0, 32'h0, 32'h0};
        bit          st_b[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        bit          rv_b[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] tg_b[4]  = '{32'h4000_0300, 32'h0, 32'h4000_0400, 32'h0};
        logic [31:0] p0;
        p0 = m_pc;
        for (int k = 0; k < 5; k++) begin
            apply(1'b0, st_a[k], rv_a[k], tg_a[k], 1'b1, $urandom(), $urandom());
            n_tests++;
            if (got_vec !== exp_vec()) begin
                n_fail++; $display("FAIL pending_model k=%0d: got %h want %h", k, got_vec, exp_vec());
            end
            n_tests++;
            if (pc !== ((k < 4) ? p0 : 32'h4000_0200)) begin
                n_fail++; $display("FAIL pending_pc k=%0d: got %h want %h", k, pc, (k < 4) ? p0 : 32'h4000_0200);
            end
            clock();
        end
        p0 = m_pc;
        for (int k = 0; k < 4; k++) begin
            apply(1'b0, st_b[k], rv_b[k], tg_b[k], 1'b1, $urandom(), $urandom());
            n_tests++;
            if (pc !== ((k < 3) ? p0 : 32'h4000_0400)) begin
                n_fail++; $display("FAIL pending_override_pc k=%0d: got %h want %h", k, pc, (k < 3) ? p0 : 32'h4000_0400);
            end
            clock();
        end
    endtask

    task automatic test_flush();
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, $urandom(), $urandom());
        clock();
        for (int k = 0; k < 5; k++) begin
            apply(1'b0, 1'b0, (k == 2), 32'h4000_0040, 1'b1, $urandom(), $urandom());
            n_tests++;
            if (got_vec !== exp_vec()) begin
                n_fail++; $display("FAIL flush_model k=%0d: got %h want %h", k, got_vec, exp_vec());
            end
            if (k == 2) begin
                n_tests++;
                if (pc !== 32'h4000_0008) begin
                    n_fail++; $display("FAIL flush_setup_pc: got %h want 40000008", pc);
                end
            end
            if (k == 3) begin
                n_tests++;
                if (instr_pc !== 32'h4000_0008 || instr_valid !== !FLUSH || instr !== (FLUSH ? NOP : bios_dout)) begin
                    n_fail++; $display("FAIL flush_slot: got ipc=%h v=%b instr=%h want ipc=40000008 v=%b instr=%h",
                                       instr_pc, instr_valid, instr, !FLUSH, FLUSH ? NOP : bios_dout);
                end
            end
            if (k == 4) begin
                n_tests++;
                if (instr_pc !== 32'h4000_0040 || instr_valid !== 1'b1) begin
                    n_fail++; $display("FAIL flush_target: got ipc=%h v=%b want ipc=40000040 v=1", instr_pc, instr_valid);
                end
            end
            clock();
        end
    endtask

    task automatic test_wrap();
        apply(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, $urandom(), $urandom());
        clock();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, $urandom(), $urandom());
        n_tests++;
        if (pc !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_align: got %h want fffffffc", pc);
        end
        clock();
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, $urandom(), $urandom());
        n_tests++;
        if (pc !== 32'h0000_0000) begin
            n_fail++; $display("FAIL wrap_pc: got %h want 00000000", pc);
        end
        n_tests++;
        if (got_vec !== exp_vec()) begin
            n_fail++; $display("FAIL wrap_model: got %h want %h", got_vec, exp_vec());
        end
        clock();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            apply($urandom_range(99) < 2, $urandom_range(99) < 30, $urandom_range(99) < 20, $urandom(),
                  1'($urandom_range(1)), $urandom(), $urandom());
            n_tests++;
            if (got_vec !== exp_vec()) begin
                n_fail++; $display("FAIL random_model i=%0d: got %h want %h", i, got_vec, exp_vec());
            end
            clock();
        end
    endtask

    initial begin
        test_reset();
        test_icache();
        test_stall();
        test_pending();
        test_flush();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
